mem_port_arbiter: RTL and testbench

Shares the single memory port between the instruction-fetch path (PC-driven) and the data path (ALU-addressed load/store), so fetch and data accesses no longer need separate ports. Grants one requester per cycle, drives the memory command, and routes the 1-cycle-latency read data back to the owner. Data requests have priority. A bounded streak counter guarantees that fetch is never starved. `stall_o` tells the processor to hold the PC when fetch loses arbitration.

---
 rtl/mem_port_arbiter.sv | 83 ++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the data path.
// Data has priority; a bounded streak counter keeps fetch from starving.
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_RESP = 2'd1,
    D_RESP  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] streak;
  logic             fetch_wins;

  // Fetch beats data only when data is idle or the data streak has hit its bound.
  assign fetch_wins = if_req_i && (!d_req_i || (streak == STREAK_MAX));
  assign if_gnt_o   = !RESET && fetch_wins;
  assign d_gnt_o    = !RESET && d_req_i && !fetch_wins;
  assign stall_o    = !RESET && if_req_i && !if_gnt_o;

  assign mem_en_o    = if_gnt_o || d_gnt_o;
  assign mem_we_o    = d_gnt_o && d_we_i;
  assign mem_addr_o  = if_gnt_o ? if_addr_i : (d_gnt_o ? d_addr_i : '0);
  assign mem_wdata_o = d_gnt_o ? d_wdata_i : '0;

  assign if_rvalid_o = (state == IF_RESP);
  assign d_rvalid_o  = (state == D_RESP);
  assign if_rdata_o  = RESET ? '0 : mem_rdata_i;
  assign d_rdata_o   = RESET ? '0 : mem_rdata_i;

  // The state names the owner of the read issued on the previous cycle.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      if (if_gnt_o)
        state <= IF_RESP;
      else if (d_gnt_o && !d_we_i)
        state <= D_RESP;
      else
        state <= IDLE;

      if (if_gnt_o || !if_req_i)
        streak <= '0;
      else if (d_gnt_o && (streak != STREAK_MAX))
        streak <= streak + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a behavioural arbiter/memory model.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        RESET;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we, stall;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .RESET(RESET),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .stall_o(stall)
  );

  function automatic logic [31:0] init_word(int i);
    case (i)
      1:       return 32'h1111_1111;
      4:       return 32'hDEAD_BEEF;
      16:      return 32'h4040_4040;
      default: return {16'hC0DE, 16'(i)};
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory device: 32 words, executes the command seen in the cycle before each edge.
  initial begin : mem_device
    logic [31:0] mem_dev [32];
    logic        c_en, c_we;
    logic [31:0] c_addr, c_wdata;
    for (int i = 0; i < 32; i++) mem_dev[i] = init_word(i);
    forever begin
      @(negedge clk);
      c_en = mem_en; c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata;
      @(posedge clk);
      #1;
      if (!RESET && c_en) begin
        if (c_we) mem_dev[c_addr[6:2]] = c_wdata;
        else      mem_rdata = mem_dev[c_addr[6:2]];
      end
    end
  end

  // Reference model: arbitration rules, response ownership and memory contents.
  initial begin : compare
    logic [31:0] mem_m [32];
    int          streak_m;
    int          owner;        // 0 none, 1 fetch, 2 data
    logic [31:0] exp_rdata;
    logic        e_ig, e_dg, e_we;
    logic [31:0] e_addr;
    for (int i = 0; i < 32; i++) mem_m[i] = init_word(i);
    streak_m = 0; owner = 0; exp_rdata = '0;
    forever begin
      @(negedge clk);
      if (RESET) begin
        chk("m_rst_if_gnt", 32'(if_gnt), 0);
        chk("m_rst_d_gnt", 32'(d_gnt), 0);
        chk("m_rst_mem_en", 32'(mem_en), 0);
        chk("m_rst_mem_we", 32'(mem_we), 0);
        chk("m_rst_if_rvalid", 32'(if_rvalid), 0);
        chk("m_rst_d_rvalid", 32'(d_rvalid), 0);
        chk("m_rst_stall", 32'(stall), 0);
        streak_m = 0; owner = 0;
      end else begin
        e_ig   = if_req && (!d_req || streak_m == MAXB);
        e_dg   = d_req && !e_ig;
        e_we   = e_dg && d_we;
        e_addr = e_ig ? if_addr : d_addr;
        chk("m_if_gnt", 32'(if_gnt), 32'(e_ig));
        chk("m_d_gnt", 32'(d_gnt), 32'(e_dg));
        chk("m_mem_en", 32'(mem_en), 32'(e_ig || e_dg));
        chk("m_mem_we", 32'(mem_we), 32'(e_we));
        chk("m_stall", 32'(stall), 32'(if_req && !e_ig));
        if (e_ig || e_dg) chk("m_mem_addr", mem_addr, e_addr);
        if (e_we) chk("m_mem_wdata", mem_wdata, d_wdata);
        chk("m_if_rvalid", 32'(if_rvalid), 32'(owner == 1));
        chk("m_d_rvalid", 32'(d_rvalid), 32'(owner == 2));
        if (owner == 1) chk("m_if_rdata", if_rdata, exp_rdata);
        if (owner == 2) chk("m_d_rdata", d_rdata, exp_rdata);
        // advance to the state after the next rising edge
        if (e_ig || (e_dg && !d_we)) exp_rdata = mem_m[e_addr[6:2]];
        if (e_we) mem_m[e_addr[6:2]] = d_wdata;
        owner = e_ig ? 1 : ((e_dg && !d_we) ? 2 : 0);
        if (e_ig || !if_req) streak_m = 0;
        else if (e_dg && streak_m < MAXB) streak_m++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic [9:0] pat_d;
    logic       gi, gd;
    RESET = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset held with both requests pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_if_gnt", 32'(if_gnt), 0);
      chk("rst_d_gnt", 32'(d_gnt), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_stall", 32'(stall), 0);
    end
    tick(); RESET = 1'b0;
    @(negedge clk);
    chk("rel_d_gnt", 32'(d_gnt), 1);
    chk("rel_if_gnt", 32'(if_gnt), 0);
    chk("rel_no_rvalid", 32'(if_rvalid | d_rvalid), 0);
    tick(); d_req = 1'b0;
    @(negedge clk);
    chk("rel_fetch_next", 32'(if_gnt), 1);
    tick(); if_req = 1'b0;
    tick();

    // Solo fetch
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("solo_if_gnt", 32'(if_gnt), 1);
    chk("solo_addr", mem_addr, 32'h10);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("solo_if_rvalid", 32'(if_rvalid), 1);
    chk("solo_if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("solo_d_rvalid", 32'(d_rvalid), 0);
    tick();

    // Contention: both read continuously
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
    pat_d = 10'b11110_11110;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cont_d_gnt", 32'(d_gnt), 32'(pat_d[9-i]));
      chk("cont_if_gnt", 32'(if_gnt), 32'(!pat_d[9-i]));
      chk("cont_stall", 32'(stall), 32'(pat_d[9-i]));
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Store versus pending fetch
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    chk("st_d_gnt", 32'(d_gnt), 1);
    chk("st_mem_we", 32'(mem_we), 1);
    chk("st_wdata", mem_wdata, 32'h55);
    tick(); d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("st_fetch_gnt", 32'(if_gnt), 1);
    chk("st_no_d_rvalid", 32'(d_rvalid), 0);
    tick(); if_req = 1'b0;
    tick();

    // Pipelined fetch then load, then read back the store
    if_req = 1'b1; if_addr = 32'h4;
    @(negedge clk);
    chk("pipe_if_gnt", 32'(if_gnt), 1);
    tick(); if_req = 1'b0; d_req = 1'b1; d_addr = 32'h40;
    @(negedge clk);
    chk("pipe_d_gnt", 32'(d_gnt), 1);
    chk("pipe_if_rvalid", 32'(if_rvalid), 1);
    chk("pipe_if_rdata", if_rdata, 32'h1111_1111);
    tick(); d_addr = 32'h20;
    @(negedge clk);
    chk("pipe_d_rvalid", 32'(d_rvalid), 1);
    chk("pipe_d_rdata", d_rdata, 32'h4040_4040);
    tick(); d_req = 1'b0;
    @(negedge clk);
    chk("store_readback", d_rdata, 32'h55);
    tick();

    // Reset asserted between a load grant and its response edge
    d_req = 1'b1; d_addr = 32'h40;
    @(negedge clk);
    chk("rmid_d_gnt", 32'(d_gnt), 1);
    #2 RESET = 1'b1;
    tick(); d_req = 1'b0;
    @(negedge clk);
    chk("rmid_no_rvalid", 32'(d_rvalid), 0);
    tick(); RESET = 1'b0;
    @(negedge clk);
    chk("rmid_after_rel", 32'(d_rvalid | if_rvalid), 0);
    tick();
    @(negedge clk);
    chk("rmid_idle", 32'(d_rvalid | if_rvalid), 0);

    // Randomized traffic; requesters hold until granted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      gi = if_gnt; gd = d_gnt;
      tick();
      if (!if_req || gi) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = {25'd0, 5'($urandom), 2'b00};
      end
      if (!d_req || gd) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = {25'd0, 5'($urandom), 2'b00};
        d_wdata = $urandom;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
